// File: rtl/bcd_display_formatter_if.sv
// Bundle of the request and display-output signals exchanged between the
// binary source and the BCD display formatter.
interface bcd_display_formatter_if #(
    parameter int BIN_W = 27
);
    logic             start;
    logic [BIN_W-1:0] value;
    logic             dot_en;
    logic [2:0]       dot_pos;
    logic [31:0]      digit;
    logic [7:0]       en_digit;
    logic [7:0]       en_dot;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, value, dot_en, dot_pos,
        input  digit, en_digit, en_dot, busy, done, overflow
    );

    modport slave (
        input  start, value, dot_en, dot_pos,
        output digit, en_digit, en_dot, busy, done, overflow
    );
endinterface

// File: rtl/bcd_display_formatter.sv
// Sequential double-dabble binary-to-BCD converter feeding an 8-digit display;
// blanks leading zeros, places a decimal point and saturates above 99,999,999.
module bcd_display_formatter #(
    parameter int BIN_W    = 27,
    parameter bit LZ_BLANK = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    bcd_display_formatter_if.slave bus
);
    localparam logic [31:0] MAX_DEC = 32'd99999999;
    localparam logic [4:0]  ITER    = 5'(BIN_W);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_LOAD    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BIN_W-1:0] r_bin;
    logic [31:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic             r_ovf_pend;
    logic             r_dot_en;
    logic [2:0]       r_dot_pos;
    logic [31:0]      r_digit;
    logic [7:0]       r_en_digit;
    logic [7:0]       r_en_dot;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;
    logic [31:0]      w_bcd_adj;
    logic [31:0]      w_value_ext;
    logic [2:0]       w_msd;
    logic [2:0]       w_lim;
    logic [7:0]       w_en_digit;
    logic [7:0]       w_en_dot;

    assign w_value_ext = 32'(bus.value);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: start is only honoured in IDLE, so it is dropped while busy or in LOAD
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_CONVERT;
                else           w_state_nxt = S_IDLE;
            end
            S_CONVERT: begin
                if (r_cnt == 5'd1) w_state_nxt = S_LOAD;
                else               w_state_nxt = S_CONVERT;
            end
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Add-3 correction of every nibble ahead of the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 8; i++) begin
            w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                             : r_bcd[4*i +: 4];
        end
    end

    // Display enables from the finished BCD word; the dot position extends the visible span
    always_comb begin
        w_msd      = 3'd0;
        w_en_digit = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_msd = (r_bcd[4*i +: 4] != 4'd0) ? 3'(i) : w_msd;
        end
        if (r_dot_en && (r_dot_pos > w_msd)) w_lim = r_dot_pos;
        else                                  w_lim = w_msd;
        if (r_ovf_pend || (LZ_BLANK == 1'b0)) begin
            w_en_digit = 8'hFF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                w_en_digit[i] = (3'(i) <= w_lim);
            end
        end
        if (r_dot_en) w_en_dot = 8'h01 << r_dot_pos;
        else          w_en_dot = 8'h00;
    end

    // Conversion datapath and atomically updated output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin      <= '0;
            r_bcd      <= 32'h00000000;
            r_cnt      <= 5'd0;
            r_ovf_pend <= 1'b0;
            r_dot_en   <= 1'b0;
            r_dot_pos  <= 3'd0;
            r_digit    <= 32'h00000000;
            r_en_digit <= 8'h01;
            r_en_dot   <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin      <= bus.value;
                        r_bcd      <= 32'h00000000;
                        r_cnt      <= ITER;
                        r_ovf_pend <= (w_value_ext > MAX_DEC);
                        r_dot_en   <= bus.dot_en;
                        r_dot_pos  <= bus.dot_pos;
                        r_busy     <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    r_bcd <= {w_bcd_adj[30:0], r_bin[BIN_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - 5'd1;
                end
                S_LOAD: begin
                    r_digit    <= r_ovf_pend ? 32'h99999999 : r_bcd;
                    r_en_digit <= w_en_digit;
                    r_en_dot   <= w_en_dot;
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.digit    = r_digit;
    assign bus.en_digit = r_en_digit;
    assign bus.en_dot   = r_en_dot;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_bcd_display_formatter.sv
// Self-checking bench: fixed vector table, random values against a decimal
// arithmetic model, and hand sequences for ignored starts and reset abort.
module tb_bcd_display_formatter;
    localparam int BIN_W = 27;
    localparam int LAT   = BIN_W + 1;

    typedef struct {
        logic [26:0] value;
        bit          dot_en;
        logic [2:0]  dot_pos;
        logic [31:0] digit;
        logic [7:0]  en_digit;
        logic [7:0]  en_dot;
        bit          ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bcd_display_formatter_if #(.BIN_W(BIN_W)) bus ();
    bcd_display_formatter_if #(.BIN_W(BIN_W)) bus_nb ();

    bcd_display_formatter #(.BIN_W(BIN_W), .LZ_BLANK(1'b1)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    bcd_display_formatter #(.BIN_W(BIN_W), .LZ_BLANK(1'b0)) dut_nb (
        .clk (clk), .rst (rst), .bus (bus_nb.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits by repeated division, enables from digit significance.
    function automatic void model(input int unsigned v, input bit de, input logic [2:0] dp,
                                  input bit lz, output logic [31:0] d, output logic [7:0] en,
                                  output logic [7:0] dot, output bit ovf);
        int unsigned t;
        int          m;
        d   = 32'h0;
        m   = 0;
        ovf = (v > 32'd99999999);
        t   = v;
        for (int i = 0; i < 8; i++) begin
            d[4*i +: 4] = 4'(t % 10);
            if ((t % 10) != 0) m = i;
            t = t / 10;
        end
        if (de && (int'(dp) > m)) m = int'(dp);
        en  = 8'((9'd1 << (m + 1)) - 9'd1);
        dot = de ? (8'h01 << dp) : 8'h00;
        if (ovf) begin
            d  = 32'h99999999;
            en = 8'hFF;
        end
        if (!lz) en = 8'hFF;
    endfunction

    // One conversion on the main DUT with latency, busy and output-hold monitoring.
    task automatic run_vec(input string name, input logic [26:0] v, input bit de,
                           input logic [2:0] dp, input logic [31:0] ed, input logic [7:0] een,
                           input logic [7:0] edot, input bit eovf);
        logic [31:0] d0;
        logic [7:0]  e0;
        int          lat;
        bit          busy_ok;
        bit          hold_ok;
        @(negedge clk);
        bus.value   = v;
        bus.dot_en  = de;
        bus.dot_pos = dp;
        bus.start   = 1'b1;
        d0 = bus.digit;
        e0 = bus.en_digit;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.value   = 27'($urandom);
        bus.dot_en  = ~de;
        bus.dot_pos = ~dp;
        busy_ok = bus.busy;
        hold_ok = 1'b1;
        lat     = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if ((bus.digit !== d0) || (bus.en_digit !== e0)) hold_ok = 1'b0;
        end
        check({name, ".latency"}, 32'(lat), 32'(LAT));
        check({name, ".busy_during"}, 32'(busy_ok), 32'd1);
        check({name, ".hold_during"}, 32'(hold_ok), 32'd1);
        check({name, ".busy_after"}, 32'(bus.busy), 32'd0);
        check({name, ".digit"}, bus.digit, ed);
        check({name, ".en_digit"}, 32'(bus.en_digit), 32'(een));
        check({name, ".en_dot"}, 32'(bus.en_dot), 32'(edot));
        check({name, ".overflow"}, 32'(bus.overflow), 32'(eovf));
        @(posedge clk);
        #1;
        check({name, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        vec_t        tbl [10];
        logic [31:0] md;
        logic [7:0]  men;
        logic [7:0]  mdot;
        bit          movf;
        int unsigned rv;
        bit          rde;
        logic [2:0]  rdp;
        int          n_done;
        logic [31:0] d_done;
        int          lat;

        tbl[0] = '{27'd0,         1'b0, 3'd0, 32'h00000000, 8'h01, 8'h00, 1'b0};
        tbl[1] = '{27'd1234,      1'b0, 3'd0, 32'h00001234, 8'h0F, 8'h00, 1'b0};
        tbl[2] = '{27'd5,         1'b1, 3'd2, 32'h00000005, 8'h07, 8'h04, 1'b0};
        tbl[3] = '{27'd99999999,  1'b0, 3'd0, 32'h99999999, 8'hFF, 8'h00, 1'b0};
        tbl[4] = '{27'd100000000, 1'b0, 3'd0, 32'h99999999, 8'hFF, 8'h00, 1'b1};
        tbl[5] = '{27'd100000000, 1'b1, 3'd7, 32'h99999999, 8'hFF, 8'h80, 1'b1};
        tbl[6] = '{27'd134217727, 1'b1, 3'd3, 32'h99999999, 8'hFF, 8'h08, 1'b1};
        tbl[7] = '{27'd10000000,  1'b0, 3'd0, 32'h10000000, 8'hFF, 8'h00, 1'b0};
        tbl[8] = '{27'd1,         1'b1, 3'd7, 32'h00000001, 8'hFF, 8'h80, 1'b0};
        tbl[9] = '{27'd50,        1'b1, 3'd0, 32'h00000050, 8'h03, 8'h01, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;    bus.value = '0;    bus.dot_en = 1'b0;    bus.dot_pos = 3'd0;
        bus_nb.start = 1'b0; bus_nb.value = '0; bus_nb.dot_en = 1'b0; bus_nb.dot_pos = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.digit", bus.digit, 32'h0);
        check("reset.en_digit", 32'(bus.en_digit), 32'h01);
        check("reset.en_dot", 32'(bus.en_dot), 32'h00);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].value, tbl[i].dot_en, tbl[i].dot_pos,
                    tbl[i].digit, tbl[i].en_digit, tbl[i].en_dot, tbl[i].ovf);
        end

        for (int r = 0; r < 30; r++) begin
            case (r % 3)
                0:       rv = $urandom_range(134217727, 0);
                1:       rv = $urandom_range(99999, 0);
                default: rv = $urandom_range(100000004, 99999996);
            endcase
            rde = 1'($urandom_range(1, 0));
            rdp = 3'($urandom_range(7, 0));
            model(rv, rde, rdp, 1'b1, md, men, mdot, movf);
            run_vec($sformatf("rand%0d", r), 27'(rv), rde, rdp, md, men, mdot, movf);
        end

        // start while busy is ignored and the running value is unaffected
        @(negedge clk);
        bus.value = 27'd42; bus.dot_en = 1'b0; bus.dot_pos = 3'd0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_done = 0;
        d_done = 32'hFFFFFFFF;
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) begin
                bus.start = 1'b1;
                bus.value = 27'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                n_done++;
                d_done = bus.digit;
            end
        end
        check("busy_start.done_count", 32'(n_done), 32'd1);
        check("busy_start.digit", d_done, 32'h00000042);
        run_vec("after_busy", 27'd7, 1'b0, 3'd0, 32'h00000007, 8'h01, 8'h00, 1'b0);

        // start coinciding with LOAD is ignored
        @(negedge clk);
        bus.value = 27'd3; bus.dot_en = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.value = 27'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("load_start.done", 32'(bus.done), 32'd1);
        check("load_start.digit", bus.digit, 32'h00000003);
        check("load_start.busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check("load_start.busy_next", 32'(bus.busy), 32'd0);

        // reset aborts a conversion and no done follows
        run_vec("pre_reset", 27'd100000000, 1'b1, 3'd3, 32'h99999999, 8'hFF, 8'h08, 1'b1);
        @(negedge clk);
        bus.value = 27'd777; bus.dot_en = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.digit", bus.digit, 32'h0);
        check("abort.en_digit", 32'(bus.en_digit), 32'h01);
        check("abort.en_dot", 32'(bus.en_dot), 32'h00);
        check("abort.overflow", 32'(bus.overflow), 32'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("abort.no_done", 32'(n_done), 32'd0);

        // build without leading-zero blanking
        @(negedge clk);
        bus_nb.value = 27'd7; bus_nb.dot_en = 1'b0; bus_nb.dot_pos = 3'd0; bus_nb.start = 1'b1;
        @(posedge clk);
        #1;
        bus_nb.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus_nb.done) begin
                lat = k;
                break;
            end
        end
        check("nolz.latency", 32'(lat), 32'(LAT));
        check("nolz.digit", bus_nb.digit, 32'h00000007);
        check("nolz.en_digit", 32'(bus_nb.en_digit), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bcd_display_formatter.md
Name: bcd_display_formatter

Overview:
- Upstream feeder for the 8-digit seven-segment controller. Takes an unsigned binary value on a start strobe and converts it to 8 packed BCD digits using a sequential shift-and-add-3 (double dabble) conversion.
- Produces the digit, en_digit and en_dot buses. Blanks leading zeros and places an optional decimal point.
- Outputs update atomically when a conversion completes, so the display never shows partial results.

Parameters:
- BIN_W, 27, width of the binary input; legal range 1..27, since 99,999,999 < 2^27.
- LZ_BLANK, 1, 1 blanks leading zeros; 0 enables all 8 digits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to convert value; honoured only when busy=0.
- value  input  BIN_W  unsigned binary number to display.
- dot_en  input  1  1 requests a decimal point.
- dot_pos  input  3  digit index (0 = rightmost) that carries the point.
- digit  output  32  packed BCD; digit[4i+3:4i] is digit i, digit 0 is the LSD.
- en_digit  output  8  per-digit enable; 1 = digit shown.
- en_dot  output  8  per-digit dot enable; 1 = dot lit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse on the cycle the outputs update.
- overflow  output  1  registered; set when the last converted value exceeded 99,999,999.

Behaviour:
- Reset values (synchronous, rst=1 at an edge):
  - digit=32'h00000000, en_digit=8'h01, en_dot=8'h00.
  - busy=0, done=0, overflow=0, FSM in IDLE.
  - Reset overrides start and aborts any conversion in progress.
- FSM states: IDLE, CONVERT, LOAD.
- IDLE:
  - On start=1, latch value, dot_en and dot_pos into internal registers.
  - Clear the 32-bit BCD shift register and set the iteration counter to BIN_W.
  - Go to CONVERT with busy=1.
- CONVERT, one iteration per cycle:
  - First, for every BCD nibble >= 5, add 3 to that nibble.
  - Then shift {bcd, bin} left by one.
  - Decrement the counter; after BIN_W iterations go to LOAD.
- LOAD:
  - Register the output buses, assert done=1 for this cycle only, drop busy, and return to IDLE.
- Latency: start sampled at edge N gives busy=1 from N. digit/en_digit/en_dot/overflow update and done=1 at edge N+BIN_W+1; busy=0 after that edge.
- start while busy=1 is ignored; it is neither queued nor a restart. start in the same cycle as LOAD is also ignored. A new start is accepted from the cycle after done.
- The input value is sampled only at start. Later changes to value, dot_en or dot_pos do not affect the running conversion.
- Overflow: if the latched value > 99,999,999, then in LOAD:
  - digit=32'h99999999 (saturate), en_digit=8'hFF, overflow=1.
  - The dot is applied as normal.
  - Otherwise overflow=0 in LOAD.
- Leading-zero blanking (LZ_BLANK=1):
  - Let m be the index of the most significant nonzero digit; m=0 if the value is 0.
  - If dot_en=1, set m = max(m, dot_pos), so "0.05"-style values keep their zeros.
  - en_digit[i]=1 for all i <= m, else 0. Digit 0 is always enabled.
  - With LZ_BLANK=0, en_digit=8'hFF.
- Dot: en_dot = dot_en ? (8'h01 << dot_pos) : 8'h00.
- Between conversions all outputs hold their last registered value. The outputs never change while busy=1.
- If BIN_W < 27, overflow can never assert; the compare logic may be constant-folded.

Test Plan:
- Reset, then value=0, start -> after BIN_W+1 cycles: done pulse, digit=32'h00000000, en_digit=8'h01, en_dot=8'h00, overflow=0.
- value=1234, dot_en=0, start -> digit=32'h00001234, en_digit=8'h0F; done exactly 28 cycles after start (BIN_W=27); busy high for 28 cycles.
- value=5, dot_en=1, dot_pos=2, start -> digit=32'h00000005, en_digit=8'h07, en_dot=8'h04.
- value=99999999, then value=100000000 -> first: digit=32'h99999999, en_digit=8'hFF, overflow=0; second: digit=32'h99999999, en_digit=8'hFF, overflow=1.
- value=42, start; at cycle 5 apply start with value=7 and change value -> exactly one done; result digit=32'h00000042. The next start after done converts 7 to digit=32'h00000007, en_digit=8'h01.
- value=777, start; assert rst at cycle 10 -> at the next edge busy=0, digit=0, en_digit=8'h01, and no done pulse follows. LZ_BLANK=0 build with value=7 -> en_digit=8'hFF.
